// File: rtl/instr_encoder_loader_if.sv
// Field-triple input stream and program-memory port of the instruction encoder/loader.
interface instr_encoder_loader_if #(
    parameter int unsigned OPCODE_WIDTH = 6,
    parameter int unsigned ADDR_WIDTH   = 5,
    parameter int unsigned I_WIDTH      = 12
);
    logic                    in_valid;
    logic                    in_ready;
    logic [OPCODE_WIDTH-1:0] in_opcode;
    logic [2:0]              in_imm;
    logic signed [2:0]       in_offset;
    logic                    in_last;
    logic                    pm_we;
    logic [ADDR_WIDTH-1:0]   pm_addr;
    logic [I_WIDTH-1:0]      pm_wdata;
    logic                    pm_re;
    logic [I_WIDTH-1:0]      pm_rdata;

    // Host/boot source plus memory side.
    modport master (
        output in_valid, in_opcode, in_imm, in_offset, in_last, pm_rdata,
        input  in_ready, pm_we, pm_addr, pm_wdata, pm_re
    );

    // Loader side.
    modport slave (
        input  in_valid, in_opcode, in_imm, in_offset, in_last, pm_rdata,
        output in_ready, pm_we, pm_addr, pm_wdata, pm_re
    );
endinterface

// File: rtl/instr_encoder_loader.sv
// Packs {opcode, imm, offset} triples into instruction words and writes them to program memory
// from address 0. Optional readback verification is enabled with `define LOADER_READBACK_EN.
module instr_encoder_loader #(
    parameter int unsigned I_WIDTH      = 12,
    parameter int unsigned OPCODE_WIDTH = 6,
    parameter int unsigned ADDR_WIDTH   = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    instr_encoder_loader_if.slave bus,
    output logic                  cpu_hold,
    output logic                  done,
    output logic [ADDR_WIDTH:0]   word_count,
    output logic                  overflow,
    output logic                  verify_err
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE   = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH:0]   CNT_ONE   = (ADDR_WIDTH + 1)'(1);

`ifdef LOADER_READBACK_EN
    typedef enum logic [2:0] {IDLE, LOAD, WRITE, READ, CHECK, DONE} state_t;
`else
    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;
`endif

    state_t                state;
    logic [ADDR_WIDTH-1:0] ptr;
    logic [I_WIDTH-1:0]    word;
    logic                  accept;
    logic                  terminal;

    assign word     = {bus.in_opcode, bus.in_imm, bus.in_offset};
    assign accept   = bus.in_valid & bus.in_ready;
    // Capacity-terminated: the pointer stops at the last address instead of wrapping.
    assign terminal = bus.in_last | (ptr == LAST_ADDR);

    assign bus.in_ready = (state == LOAD);
    assign cpu_hold     = (state == LOAD) | bus.pm_we | bus.pm_re;

`ifdef LOADER_READBACK_EN
    logic cmp_pending;
    logic term_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            ptr          <= '0;
            bus.pm_we    <= 1'b0;
            bus.pm_re    <= 1'b0;
            bus.pm_addr  <= '0;
            bus.pm_wdata <= '0;
            done         <= 1'b0;
            word_count   <= '0;
            overflow     <= 1'b0;
            verify_err   <= 1'b0;
            cmp_pending  <= 1'b0;
            term_q       <= 1'b0;
        end else begin
            bus.pm_we <= 1'b0;
            bus.pm_re <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state       <= LOAD;
                        ptr         <= '0;
                        word_count  <= '0;
                        overflow    <= 1'b0;
                        verify_err  <= 1'b0;
                        cmp_pending <= 1'b0;
                        done        <= 1'b0;
                    end
                end
                LOAD: begin
                    // Read data of the previous word is only valid in the first LOAD cycle.
                    if (cmp_pending) begin
                        cmp_pending <= 1'b0;
                        if (bus.pm_rdata != bus.pm_wdata) verify_err <= 1'b1;
                    end
                    if (accept) begin
                        state        <= WRITE;
                        bus.pm_we    <= 1'b1;
                        bus.pm_addr  <= ptr;
                        bus.pm_wdata <= word;
                        word_count   <= word_count + CNT_ONE;
                        term_q       <= terminal;
                        if (terminal) overflow <= ~bus.in_last;
                        else          ptr      <= ptr + PTR_ONE;
                    end
                end
                WRITE: begin
                    state     <= READ;
                    bus.pm_re <= 1'b1;
                end
                READ: begin
                    if (term_q) state <= CHECK;
                    else begin
                        state       <= LOAD;
                        cmp_pending <= 1'b1;
                    end
                end
                CHECK: begin
                    if (bus.pm_rdata != bus.pm_wdata) verify_err <= 1'b1;
                    state <= DONE;
                    done  <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
`else
    assign bus.pm_re = 1'b0;
    assign verify_err = 1'b0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            ptr          <= '0;
            bus.pm_we    <= 1'b0;
            bus.pm_addr  <= '0;
            bus.pm_wdata <= '0;
            done         <= 1'b0;
            word_count   <= '0;
            overflow     <= 1'b0;
        end else begin
            bus.pm_we <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state      <= LOAD;
                        ptr        <= '0;
                        word_count <= '0;
                        overflow   <= 1'b0;
                        done       <= 1'b0;
                    end
                end
                LOAD: begin
                    if (accept) begin
                        bus.pm_we    <= 1'b1;
                        bus.pm_addr  <= ptr;
                        bus.pm_wdata <= word;
                        word_count   <= word_count + CNT_ONE;
                        if (terminal) begin
                            state    <= DONE;
                            done     <= 1'b1;
                            overflow <= ~bus.in_last;
                        end else begin
                            ptr <= ptr + PTR_ONE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
`endif

endmodule
